// File: rtl/fpdiv_iter.sv
`default_nettype none
// ============================================================================
// fpdiv_iter : iterative IEEE 754 binary32 divider, restoring, 1 bit/cycle
// Rev 1.0
// ============================================================================
module fpdiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] InA,
  input  logic [31:0] InB,
  output logic [31:0] Result,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ITER = 5'd24;

  state_t      state, state_nxt;
  logic        sign_r;
  logic [7:0]  exp_a, exp_b;
  logic        a_zero, b_zero;
  logic [23:0] mb;
  logic [24:0] rem, q;
  logic [4:0]  cnt;

  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [24:0] rem_nxt;
  logic [7:0]  exp_res;
  logic [22:0] frac_res;
  logic [31:0] res_nxt;
  logic        dz_nxt;

  // Restoring step; the remainder stays below 2*MB so the shift is lossless.
  always_comb begin
    rem_ge  = (rem >= {1'b0, mb});
    rem_sub = rem_ge ? (rem - {1'b0, mb}) : rem;
    rem_nxt = rem_sub << 1;
  end

  // Normalisation and special-case selection, truncating.
  always_comb begin
    exp_res  = exp_a - exp_b + (q[24] ? 8'd127 : 8'd126);
    frac_res = q[24] ? q[23:1] : q[22:0];
    res_nxt  = {sign_r, exp_res, frac_res};
    dz_nxt   = 1'b0;
    if (b_zero && !a_zero) begin
      res_nxt = {sign_r, 8'hFF, 23'd0};
      dz_nxt  = 1'b1;
    end else if (a_zero && b_zero) begin
      res_nxt = 32'h7FC0_0000;
    end else if (a_zero) begin
      res_nxt = {sign_r, 31'd0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DIV;
      DIV:     if (cnt == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
      sign_r <= 1'b0;
      exp_a  <= 8'd0;
      exp_b  <= 8'd0;
      a_zero <= 1'b0;
      b_zero <= 1'b0;
      mb     <= 24'd0;
      rem    <= 25'd0;
      q      <= 25'd0;
      cnt    <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            sign_r <= InA[31] ^ InB[31];
            exp_a  <= InA[30:23];
            exp_b  <= InB[30:23];
            a_zero <= (InA[30:23] == 8'd0);
            b_zero <= (InB[30:23] == 8'd0);
            rem    <= {1'b0, |InA[30:23], InA[22:0]};
            mb     <= {|InB[30:23], InB[22:0]};
            q      <= 25'd0;
            cnt    <= 5'd0;
          end
        end
        DIV: begin
          rem <= rem_nxt;
          q   <= {q[23:0], rem_ge};
          cnt <= cnt + 5'd1;
        end
        DONE: begin
          Result <= res_nxt;
          dz     <= dz_nxt;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
